k12a_wake_ctrl: RTL

Front-end conditioning stage for the CPU's wake_sources and button-type gpio inputs; sits directly upstream of the CPU top level. Synchronises and debounces up to 8 raw external inputs and detects per-channel edges. Latches each qualifying edge as a pending wake request, held until the CPU leaves the halt state. Outputs drive the CPU's wake_sources port; debounced levels can also feed gpio_in.

---
 rtl/k12a_wake_ctrl_pkg.sv | 28 ++
 rtl/k12a_debounce.sv | 53 +++++
 rtl/k12a_wake_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/k12a_wake_ctrl_pkg.sv
// rtl/k12a_wake_ctrl_pkg.sv - shared types and helpers for the k12a wake controller
//
// Purpose : wake edge polarity encoding and the per-channel wake event
//           function used by k12a_wake_ctrl.
// Contents: wake_edge_t (0 = rising, 1 = falling), wake_event().
package k12a_wake_ctrl_pkg;

  typedef enum logic {
    WAKE_EDGE_RISING  = 1'b0,
    WAKE_EDGE_FALLING = 1'b1
  } wake_edge_t;

  // One-cycle wake event for a single channel: the debounced level moved in
  // the direction selected by mode, and the channel is allowed to wake.
  function automatic logic wake_event(
    input logic       st,
    input logic       st_q,
    input wake_edge_t mode,
    input logic       en
  );
    logic rise;
    logic fall;
    rise = st & ~st_q;
    fall = ~st & st_q;
    return en & ((mode == WAKE_EDGE_FALLING) ? fall : rise);
  endfunction

endpackage

// File: rtl/k12a_debounce.sv
// rtl/k12a_debounce.sv - one-channel synchroniser and debouncer
//
// Purpose : brings one asynchronous raw input into the cpu_clock domain with
//           a 2-FF synchroniser, then only accepts a new level after it has
//           differed from the current stable level for DEBOUNCE_CYCLES
//           consecutive synchronised cycles.
// Ports   : cpu_clock  - system clock
//           reset      - asynchronous, active-high reset
//           raw        - asynchronous raw input
//           level      - debounced (stable) level
module k12a_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic cpu_clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  logic                 st;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any cycle of agreement restarts the count, so a glitch shorter than
      // DEBOUNCE_CYCLES never reaches the stable level.
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = st;

endmodule

// File: rtl/k12a_wake_ctrl.sv
// rtl/k12a_wake_ctrl.sv - debounced, edge-qualified wake request latch for the CPU
//
// Purpose : conditions up to CHANNELS raw external inputs (sync + debounce),
//           detects per-channel rising/falling edges on the debounced level
//           and latches qualifying edges as pending wake requests that are
//           released when the CPU leaves halt.
// Ports   : cpu_clock    - system clock, all state on rising edge
//           reset        - asynchronous, active-high reset
//           raw_in       - asynchronous raw inputs
//           edge_mode    - per channel: 0 wake on rising, 1 wake on falling
//           enable_mask  - per channel: 1 allows the channel to raise wake
//           halted       - CPU halted flag
//           debounced    - debounced level per channel
//           pending      - latched wake requests
//           wake_sources - to CPU wake_sources, same as pending
module k12a_wake_ctrl
  import k12a_wake_ctrl_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                cpu_clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0] enable_mask,
  input  logic                halted,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] wake_sources
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] st;
  logic [CHANNELS-1:0] st_q;
  logic [CHANNELS-1:0] wake_evt;
  logic [CHANNELS-1:0] pending_q;
  logic [CHANNELS-1:0] pending_d;
  logic                halted_q;
  logic                halt_exit;

  // Per-channel conditioning.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    k12a_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_debounce (
      .cpu_clock (cpu_clock),
      .reset     (reset),
      .raw       (raw_in[ch]),
      .level     (st[ch])
    );
  end

  // Previous debounced level and previous halted flag.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      st_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      st_q     <= st;
      halted_q <= halted;
    end
  end

  // A single-cycle pulse when the CPU drops out of halt.
  assign halt_exit = halted_q & ~halted;

  // Edge events are combinational from st/st_q, so edge_mode only matters
  // at the cycle the debounced level actually moves.
  always_comb begin
    wake_evt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wake_evt[i] = wake_event(st[i], st_q[i], wake_edge_t'(edge_mode[i]),
                               enable_mask[i]);
    end
  end

  // Pending next state: a new event wins over masking and halt-exit clear,
  // so an event arriving in the clear cycle is not lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wake_evt[i]) begin
        pending_d[i] = 1'b1;
      end else if (!enable_mask[i]) begin
        pending_d[i] = 1'b0;
      end else if (halt_exit) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign debounced    = st;
  assign pending      = pending_q;
  assign wake_sources = pending_q;

endmodule
